// File: rtl/tetris_pkg.sv
// Shared Tetris datapath definitions: key table, game state codes, piece IDs and
// the bag start-point helper.
package tetris_pkg;

   typedef logic [2:0] piece_id_t;

   localparam logic [2:0] GS_PLAY = 3'b001;

   localparam int unsigned KEY_LEFT  = 0;
   localparam int unsigned KEY_RIGHT = 1;
   localparam int unsigned KEY_UP    = 2;
   localparam int unsigned KEY_DOWN  = 3;
   localparam int unsigned KEY_SPACE = 4;
   localparam int unsigned KEY_ENTER = 5;
   localparam int unsigned NUM_KEY_CODES = 6;

   // Entry [0] is LEFT, matching the key index constants above.
   localparam logic [NUM_KEY_CODES-1:0][7:0] KEY_CODE =
      {8'd40, 8'd44, 8'd81, 8'd82, 8'd79, 8'd80};

   localparam piece_id_t PIECE_NONE = 3'd0;
   localparam piece_id_t PIECE_O    = 3'd1;
   localparam piece_id_t PIECE_T    = 3'd2;
   localparam piece_id_t PIECE_RL   = 3'd3;
   localparam piece_id_t PIECE_RF   = 3'd4;
   localparam piece_id_t PIECE_LL   = 3'd5;
   localparam piece_id_t PIECE_LF   = 3'd6;
   localparam piece_id_t PIECE_I    = 3'd7;

   // Out-of-range random values fold onto piece 1.
   function automatic piece_id_t bag_start(input logic [2:0] rnd, input int unsigned n);
      if (rnd == 3'd0 || 32'(rnd) > n) begin
         return 3'd1;
      end
      return rnd;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// One key channel: press edge detect plus frame-paced delayed auto-repeat.
module key_repeat
   import tetris_pkg::*;
#(
   parameter logic [7:0]  CODE       = 8'd80,
   parameter bit          REPEAT_EN  = 1'b1,
   parameter int unsigned DAS_DELAY  = 16,
   parameter int unsigned ARR_PERIOD = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       frame_tick_i,
   input  logic [7:0] keycode_i,
   output logic       key_press_o
);

   localparam int unsigned CNT_MAX = DAS_DELAY + ARR_PERIOD;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   logic          match;
   logic          match_q;
   logic          rep;
   logic          press_d, press_q;
   logic [CW-1:0] hold_q, hold_d, hold_inc;

   always_comb begin
      match    = (keycode_i == CODE);
      hold_d   = hold_q;
      rep      = 1'b0;
      hold_inc = (hold_q == CW'(CNT_MAX)) ? hold_q : hold_q + 1'b1;
      if (!REPEAT_EN || !match) begin
         hold_d = '0;
      end else if (frame_tick_i) begin
         hold_d = hold_inc;
         if (hold_inc == CW'(DAS_DELAY)) begin
            rep = 1'b1;
         end else if (hold_inc == CW'(CNT_MAX)) begin
            // Reloading keeps every later repeat ARR_PERIOD ticks apart.
            rep    = 1'b1;
            hold_d = CW'(DAS_DELAY);
         end
      end
      press_d = (match & ~match_q) | rep;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         match_q <= 1'b0;
         hold_q  <= '0;
         press_q <= 1'b0;
      end else begin
         match_q <= match;
         hold_q  <= hold_d;
         press_q <= press_d;
      end
   end

   assign key_press_o = press_q;

endmodule

// File: rtl/piece_spawn_ctrl.sv
// Spawn/input controller: 7-bag randomiser feeding a preview FIFO, spawn handshake
// and per-key press/auto-repeat pulse generation.
module piece_spawn_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned         NUM_PIECES    = 7,
   parameter int unsigned         PREVIEW_DEPTH = 3,
   parameter int unsigned         NUM_KEYS      = 6,
   parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = 6'b001011,
   parameter int unsigned         DAS_DELAY     = 16,
   parameter int unsigned         ARR_PERIOD    = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       frame_clk_i,
   input  logic [7:0]                 keycode_i,
   input  logic [2:0]                 randnum_i,
   input  logic [2:0]                 game_state_i,
   input  logic                       restart_i,
   input  logic                       spawn_req_i,
   output logic                       spawn_ack_o,
   output logic [NUM_PIECES-1:0]      active_o,
   output logic [3*PREVIEW_DEPTH-1:0] next_pieces_o,
   output logic [NUM_KEYS-1:0]        key_press_o
);

   localparam int unsigned CNT_W = $clog2(PREVIEW_DEPTH + 1);

   logic                  frame_clk_q, frame_tick;
   logic                  req_q, pend_q, pend_d, pend_now;
   logic                  can_pop, do_push, found;
   logic [CNT_W-1:0]      count_q, count_d, tail;
   logic [NUM_PIECES-1:0] used_q, used_d, used_set;
   logic [NUM_PIECES-1:0] active_q, active_d;
   logic                  ack_q, ack_d;
   piece_id_t             queue_q [PREVIEW_DEPTH];
   piece_id_t             queue_d [PREVIEW_DEPTH];
   piece_id_t             start, draw_id;
   int unsigned           idx;

   assign frame_tick = frame_clk_i & ~frame_clk_q;

   always_comb begin
      // A request is honoured only once per rising edge of spawn_req.
      pend_now = spawn_req_i & (pend_q | ~req_q);
      can_pop  = pend_now && (game_state_i == GS_PLAY) && (count_q != '0);
      do_push  = (count_q < CNT_W'(PREVIEW_DEPTH));
      tail     = can_pop ? count_q - 1'b1 : count_q;

      start    = bag_start(randnum_i, NUM_PIECES);
      draw_id  = '0;
      found    = 1'b0;
      used_set = used_q;
      idx      = 0;
      for (int unsigned off = 0; off < NUM_PIECES; off++) begin
         idx = (32'(start) - 1 + off) % NUM_PIECES;
         if (!found && !used_q[idx]) begin
            found         = 1'b1;
            draw_id       = piece_id_t'(idx + 1);
            used_set[idx] = 1'b1;
         end
      end

      queue_d  = queue_q;
      count_d  = count_q;
      used_d   = used_q;
      pend_d   = pend_now;
      ack_d    = 1'b0;
      active_d = '0;
      if (restart_i) begin
         for (int i = 0; i < PREVIEW_DEPTH; i++) queue_d[i] = '0;
         count_d = '0;
         used_d  = '0;
         pend_d  = 1'b0;
      end else begin
         if (can_pop) begin
            ack_d    = 1'b1;
            active_d = NUM_PIECES'(1) << (queue_q[0] - 3'd1);
            pend_d   = 1'b0;
            for (int i = 0; i < PREVIEW_DEPTH - 1; i++) queue_d[i] = queue_q[i+1];
            queue_d[PREVIEW_DEPTH-1] = '0;
         end
         if (do_push) begin
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
               if (CNT_W'(i) == tail) queue_d[i] = draw_id;
            end
            used_d = (used_set == '1) ? '0 : used_set;
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(can_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         frame_clk_q <= 1'b0;
         req_q       <= 1'b0;
         pend_q      <= 1'b0;
         count_q     <= '0;
         used_q      <= '0;
         ack_q       <= 1'b0;
         active_q    <= '0;
         for (int i = 0; i < PREVIEW_DEPTH; i++) queue_q[i] <= '0;
      end else begin
         frame_clk_q <= frame_clk_i;
         req_q       <= spawn_req_i;
         pend_q      <= pend_d;
         count_q     <= count_d;
         used_q      <= used_d;
         ack_q       <= ack_d;
         active_q    <= active_d;
         for (int i = 0; i < PREVIEW_DEPTH; i++) queue_q[i] <= queue_d[i];
      end
   end

   always_comb begin
      next_pieces_o = '0;
      for (int i = 0; i < PREVIEW_DEPTH; i++) next_pieces_o[3*i +: 3] = queue_q[i];
   end

   assign spawn_ack_o = ack_q;
   assign active_o    = active_q;

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_repeat #(
         .CODE       (KEY_CODE[gi]),
         .REPEAT_EN  (REPEAT_MASK[gi]),
         .DAS_DELAY  (DAS_DELAY),
         .ARR_PERIOD (ARR_PERIOD)
      ) u_key (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .frame_tick_i (frame_tick),
         .keycode_i    (keycode_i),
         .key_press_o  (key_press_o[gi])
      );
   end

endmodule

// File: tb/tb_piece_spawn_ctrl.sv
// Bench for piece_spawn_ctrl: directed tables and sequences plus random traffic
// checked every cycle against a queue/bag reference model.
module tb_piece_spawn_ctrl;

   localparam int NP    = 7;
   localparam int DEPTH = 3;
   localparam int NK    = 6;
   localparam int DAS   = 16;
   localparam int ARR   = 4;
   localparam logic [NK-1:0] RMASK = 6'b001011;

   logic             clk = 1'b0;
   logic             rst;
   logic             frame_clk;
   logic [7:0]       keycode;
   logic [2:0]       randnum;
   logic [2:0]       game_state;
   logic             restart;
   logic             spawn_req;
   logic             spawn_ack;
   logic [NP-1:0]    active;
   logic [3*DEPTH-1:0] next_pieces;
   logic [NK-1:0]    key_press;

   always #5 clk = ~clk;

   piece_spawn_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .frame_clk_i   (frame_clk),
      .keycode_i     (keycode),
      .randnum_i     (randnum),
      .game_state_i  (game_state),
      .restart_i     (restart),
      .spawn_req_i   (spawn_req),
      .spawn_ack_o   (spawn_ack),
      .active_o      (active),
      .next_pieces_o (next_pieces),
      .key_press_o   (key_press)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int codes [NK] = '{80, 79, 82, 81, 44, 40};

   // Reference model state
   int            mq[$];
   bit [NP:1]     m_used;
   bit            m_prev_frame, m_prev_req, m_pend;
   bit            m_prev_match [NK];
   int            m_ticks [NK];
   logic          exp_ack;
   logic [NP-1:0] exp_active;
   logic [NK-1:0] exp_press;

   typedef struct {
      logic [2:0] rn;
      int         seq [7];
   } draw_vec_t;
   draw_vec_t vecs [4];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_used       = '0;
      m_prev_frame = 1'b0;
      m_prev_req   = 1'b0;
      m_pend       = 1'b0;
      exp_ack      = 1'b0;
      exp_active   = '0;
      exp_press    = '0;
      for (int i = 0; i < NK; i++) begin
         m_prev_match[i] = 1'b0;
         m_ticks[i]      = 0;
      end
   endfunction

   // Smallest unused ID at or above the start point, else the smallest unused ID.
   function automatic int model_draw(input int rn);
      int start, best, low;
      start = (rn == 0 || rn > NP) ? 1 : rn;
      best  = 0;
      low   = 0;
      for (int id = NP; id >= 1; id--) begin
         if (!m_used[id]) begin
            low = id;
            if (id >= start) best = id;
         end
      end
      return (best != 0) ? best : low;
   endfunction

   function automatic void model_step();
      bit tick, m, pop;
      int sz, id;
      tick         = frame_clk && !m_prev_frame;
      m_prev_frame = frame_clk;
      for (int i = 0; i < NK; i++) begin
         m = (int'(keycode) == codes[i]);
         exp_press[i] = m && !m_prev_match[i];
         if (!m) begin
            m_ticks[i] = 0;
         end else if (tick && RMASK[i]) begin
            m_ticks[i]++;
            if (m_ticks[i] >= DAS && (m_ticks[i] - DAS) % ARR == 0) exp_press[i] = 1'b1;
         end
         m_prev_match[i] = m;
      end
      if (!spawn_req) m_pend = 1'b0;
      else if (!m_prev_req) m_pend = 1'b1;
      m_prev_req = spawn_req;
      exp_ack    = 1'b0;
      exp_active = '0;
      if (restart) begin
         mq.delete();
         m_used = '0;
         m_pend = 1'b0;
      end else begin
         sz  = mq.size();
         pop = m_pend && (game_state == 3'b001) && (sz > 0);
         if (pop) begin
            exp_ack    = 1'b1;
            exp_active = NP'(1) << (mq[0] - 1);
            void'(mq.pop_front());
            m_pend = 1'b0;
         end
         if (sz < DEPTH) begin
            id = model_draw(int'(randnum));
            mq.push_back(id);
            m_used[id] = 1'b1;
            if (m_used == '1) m_used = '0;
         end
      end
   endfunction

   task automatic check_outputs();
      logic [3*DEPTH-1:0] exp_np;
      exp_np = '0;
      for (int i = 0; i < mq.size(); i++) exp_np[3*i +: 3] = 3'(mq[i]);
      cmp("spawn_ack", 32'(spawn_ack), 32'(exp_ack));
      cmp("active", 32'(active), 32'(exp_active));
      cmp("next_pieces", 32'(next_pieces), 32'(exp_np));
      cmp("key_press", 32'(key_press), 32'(exp_press));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_outputs();
   endtask

   function automatic int slots(input logic [3*DEPTH-1:0] np);
      int n;
      n = 0;
      for (int i = 0; i < DEPTH; i++) if (np[3*i +: 3] != 3'd0) n++;
      return n;
   endfunction

   function automatic int onehot_id(input logic [NP-1:0] oh);
      int id;
      id = 0;
      for (int i = 0; i < NP; i++) if (oh[i]) id = i + 1;
      return id;
   endfunction

   task automatic pop_one(output int id);
      spawn_req = 1'b1;
      cycle();
      cmp("pop_ack", 32'(spawn_ack), 32'd1);
      id = onehot_id(active);
      spawn_req = 1'b0;
      cycle();
   endtask

   initial begin
      int id, acks, old_head, ack_active, refill, r;
      int hits[$];
      int ticks;
      logic [NP:1] seen;
      logic [3*DEPTH-1:0] exp3;

      vecs[0] = '{3'd0, '{1, 2, 3, 4, 5, 6, 7}};
      vecs[1] = '{3'd5, '{5, 6, 7, 1, 2, 3, 4}};
      vecs[2] = '{3'd7, '{7, 1, 2, 3, 4, 5, 6}};
      vecs[3] = '{3'd3, '{3, 4, 5, 6, 7, 1, 2}};

      rst = 1'b1; frame_clk = 1'b0; keycode = 8'd0; randnum = 3'd0;
      game_state = 3'b000; restart = 1'b0; spawn_req = 1'b0;
      model_reset();
      #1;
      check_outputs();
      repeat (2) cycle();
      rst = 1'b0;

      // Fill latency after reset
      randnum = 3'($urandom_range(7));
      cycle();
      cycle();
      cmp("fill_after_2", 32'(slots(next_pieces)), 32'd2);
      cycle();
      cmp("fill_after_3", 32'(slots(next_pieces)), 32'd3);

      // First bag drawn after reset is a permutation
      game_state = 3'b001;
      seen = '0;
      for (int k = 0; k < 7; k++) begin
         randnum = 3'($urandom_range(7));
         pop_one(id);
         if (id >= 1 && id <= NP) seen[id] = 1'b1;
      end
      cmp("bag_permutation", 32'(seen), 32'h7f);

      // Draw order with randnum held constant
      for (int v = 0; v < 4; v++) begin
         randnum = vecs[v].rn;
         restart = 1'b1;
         cycle();
         restart = 1'b0;
         repeat (3) cycle();
         exp3 = 9'(vecs[v].seq[0]) | (9'(vecs[v].seq[1]) << 3) | (9'(vecs[v].seq[2]) << 6);
         cmp("draw_preview", 32'(next_pieces), 32'(exp3));
         for (int k = 0; k < 8; k++) begin
            pop_one(id);
            cmp("draw_order", 32'(id), 32'(vecs[v].seq[k % 7]));
         end
      end

      // LEFT held for 30 frame ticks
      game_state = 3'b000;
      keycode = 8'd0;
      cycle();
      hits.delete();
      ticks = 0;
      keycode = 8'd80;
      cycle();
      if (key_press[0]) hits.push_back(ticks);
      while (ticks < 30) begin
         frame_clk = 1'b1;
         ticks++;
         cycle();
         if (key_press[0]) hits.push_back(ticks);
         frame_clk = 1'b0;
         cycle();
         if (key_press[0]) hits.push_back(ticks);
      end
      cmp("left_pulses", 32'(hits.size()), 32'd5);
      if (hits.size() == 5) begin
         cmp("left_press", 32'(hits[0]), 32'd0);
         cmp("left_rep1", 32'(hits[1]), 32'd16);
         cmp("left_rep2", 32'(hits[2]), 32'd20);
         cmp("left_rep3", 32'(hits[3]), 32'd24);
         cmp("left_rep4", 32'(hits[4]), 32'd28);
      end

      // ENTER held: no repeat
      keycode = 8'd40;
      acks = 0;
      for (int k = 0; k < 60; k++) begin
         frame_clk = k[0];
         cycle();
         if (key_press[5]) acks++;
      end
      cmp("enter_pulses", 32'(acks), 32'd1);
      keycode = 8'd0;
      frame_clk = 1'b0;
      cycle();

      // Held request in PLAY spawns exactly once
      game_state = 3'b001;
      repeat (3) cycle();
      old_head = int'(next_pieces[2:0]);
      acks = 0; ack_active = 0; refill = -1;
      spawn_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (acks == 1 && refill < 0) refill = slots(next_pieces);
         if (spawn_ack) begin
            acks++;
            ack_active = int'(active);
         end
      end
      cmp("held_req_acks", 32'(acks), 32'd1);
      cmp("held_req_active", 32'(ack_active), 32'(NP'(1) << (old_head - 1)));
      cmp("held_req_refill", 32'(refill), 32'd3);
      spawn_req = 1'b0;
      cycle();

      // Not PLAY: ignored; restart cancels the pending edge
      game_state = 3'b000;
      spawn_req = 1'b1;
      acks = 0;
      repeat (10) begin
         cycle();
         if (spawn_ack) acks++;
      end
      cmp("nonplay_acks", 32'(acks), 32'd0);
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      cmp("restart_clear", 32'(next_pieces), 32'd0);
      cmp("restart_no_ack", 32'(spawn_ack), 32'd0);
      game_state = 3'b001;
      acks = 0;
      repeat (3) begin
         cycle();
         if (spawn_ack) acks++;
      end
      cmp("restart_refill", 32'(slots(next_pieces)), 32'd3);
      cmp("restart_cancel", 32'(acks), 32'd0);
      spawn_req = 1'b0;
      cycle();

      // Asynchronous reset while an ack is showing
      spawn_req = 1'b1;
      @(posedge clk);
      model_step();
      #2;
      cmp("ack_before_reset", 32'(spawn_ack), 32'd1);
      rst = 1'b1;
      #1;
      cmp("async_rst_ack", 32'(spawn_ack), 32'd0);
      cmp("async_rst_active", 32'(active), 32'd0);
      cmp("async_rst_queue", 32'(next_pieces), 32'd0);
      cmp("async_rst_keys", 32'(key_press), 32'd0);
      model_reset();
      @(negedge clk);
      spawn_req = 1'b0;
      cycle();
      rst = 1'b0;

      // Random traffic against the model
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(149) == 0) begin
            r = $urandom_range(7);
            if (r < NK) keycode = 8'(codes[r]);
            else if (r == 6) keycode = 8'd0;
            else keycode = 8'($urandom_range(255));
         end
         frame_clk  = 1'($urandom_range(1));
         randnum    = 3'($urandom_range(7));
         game_state = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'b001;
         restart    = ($urandom_range(63) == 0);
         if ($urandom_range(2) == 0) spawn_req = ~spawn_req;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/piece_spawn_ctrl.md
# piece_spawn_ctrl

Parametrised next-generation spawn/input controller for the Tetris datapath. It sits between the USB keycode register and the random source on one side and the piece movement FSMs on the other. It turns held keycodes into one-cycle press pulses, with optional frame-paced auto-repeat per key. It draws pieces with a 7-bag randomiser into a preview queue and issues one-hot piece activation on a spawn request/acknowledge handshake.

## Interface
Parameters:
- NUM_PIECES, 7: piece types; piece IDs are 1..NUM_PIECES, 0 = none.
- PREVIEW_DEPTH, 3: preview FIFO depth, 1..8.
- NUM_KEYS, 6: key channels; keycodes come from the package table KEY_CODE[NUM_KEYS].
- REPEAT_MASK, 6'b001011: bit i set enables auto-repeat on key i.
- DAS_DELAY, 16: frame ticks of hold before the first repeat, ≥1.
- ARR_PERIOD, 4: frame ticks between repeats, ≥1.

Ports:
- Clk, in, 1: system clock; the only clock.
- Reset, in, 1: asynchronous, active-high reset.
- frame_clk, in, 1: vertical-sync-rate strobe, already synchronous to Clk.
- keycode, in, 8: current USB keycode, 0 = none.
- randnum, in, 3: free-running random value.
- Game_State, in, 3: 3'b001 = PLAY.
- restart, in, 1: one-cycle pulse; flushes the queue and the bag.
- spawn_req, in, 1: level; held by the consumer until spawn_ack.
- spawn_ack, out, 1: one-cycle pulse; the head piece has been popped.
- active, out, NUM_PIECES: one-hot, valid only with spawn_ack; bit k-1 = piece k.
- next_pieces, out, 3*PREVIEW_DEPTH: queue contents, head in the LSBs, empty slots 0.
- key_press, out, NUM_KEYS: one-cycle press/repeat pulses.

## Operation
- Frame tick: frame_tick = frame_clk & ~frame_clk_d (rising edge), one Clk cycle wide.
- Key channel i:
  - match = (keycode == KEY_CODE[i]).
  - key_press[i] pulses on match & ~match_d.
  - Repeat-enabled channels keep a hold counter, cleared while ~match and incremented on frame_tick while match.
  - The counter saturates at DAS_DELAY + ARR_PERIOD and reloads to DAS_DELAY after each repeat.
  - A repeat pulse fires on the frame_tick where the counter reaches DAS_DELAY, then every ARR_PERIOD ticks after that.
  - A keycode change to a different key restarts that key's counter from 0.
- Bag:
  - used mask, NUM_PIECES bits.
  - Draw: start = (randnum==0 || randnum>NUM_PIECES) ? 1 : randnum. Choose the first unused ID at or after start, wrapping NUM_PIECES→1.
  - The drawn ID's mask bit is set.
  - If the updated mask is all ones, it clears in the same cycle, so a new bag starts.
- Queue fill: at most one draw per cycle, whenever count < PREVIEW_DEPTH, in any Game_State.
- Spawn:
  - spawn_req & (Game_State==3'b001) & (count>0) pops the head on the next edge.
  - The same edge raises spawn_ack and active = onehot(head) for one cycle.
  - After a pop, spawn_req must drop for at least one cycle before the next request is honoured (rising-edge qualified). A held level therefore never causes a double spawn.
- Simultaneous pop and push: the count is unchanged; the new piece enters at the tail after the shift.
- Empty queue with request pending: no ack; the request is served once a piece arrives.
- Game_State ≠ PLAY: requests are ignored, the queue keeps filling, and key channels operate normally.
- restart: has priority over pop and push that cycle. It sets count=0, mask=0 and next_pieces=0, and cancels any pending request edge.

## Timing
- Reset values:
  - All outputs 0.
  - count 0, mask 0, hold counters 0, frame_clk_d 0.
  - match_d and request-edge registers 0.
- Latencies:
  - Queue full PREVIEW_DEPTH cycles after Reset or restart deassertion.
  - keycode change → key_press: 1 cycle.
  - spawn_req rise (queue non-empty, PLAY) → spawn_ack/active: 1 cycle.
  - next_pieces reflects a pop on the same edge as spawn_ack.
- Reset asserted mid-operation: everything returns to reset values immediately, asynchronously. No partial ack pulse survives.

## Structure
- Shared package tetris_pkg holds:
  - KEY_CODE table: LEFT 80, RIGHT 79, UP 82, DOWN 81, SPACE 44, ENTER 40.
  - Key index constants.
  - GS_PLAY = 3'b001.
  - piece_id_t (3-bit).
  - Piece ID constants: O=1, T=2, RL=3, RF=4, LL=5, LF=6, I=7.
- Sub-module key_repeat: one instance per channel, generated, containing the edge detect and hold counter. The bag and FIFO stay in the top module.

## Test plan
- Reset, no requests → queue fills in 3 cycles; the first 7 drawn IDs across successive pops form a permutation of 1..7.
- randnum held at 0 → draws 1,2,3,4,5,6,7,1,… in order; randnum held at 5 → 5,6,7,1,2,3,4.
- keycode=80 held for 30 frame ticks on LEFT (repeat enabled) → presses at cycle+1, then at ticks 16, 20, 24, 28.
- keycode=40 held → exactly one key_press[ENTER] pulse.
- Game_State=001, spawn_req held high 10 cycles → exactly one spawn_ack, active one-hot matching the old next_pieces[2:0]; the queue refills to 3 the next cycle.
- Game_State=000 with spawn_req → no ack. restart during a pending request → next_pieces=0, no ack; the queue refills within 3 cycles.
